// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Stalls the pipeline on a miss, writes back a dirty victim, then refills the line from memory.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 27 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic [2:0]            word;
  logic                  hit;
  logic                  idle_hit;
  logic                  refill_done;
  logic [1:0]            unused_byte_offset;

  assign unused_byte_offset = cpu_addr_i[1:0];
  assign word    = cpu_addr_i[4:2];
  assign idx     = cpu_addr_i[4+INDEX_BITS:5];
  assign req_tag = cpu_addr_i[31:5+INDEX_BITS];

  assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign idle_hit    = (state_q == IDLE) & hit;
  assign refill_done = (state_q == ALLOCATE) & mem_ack_i;
  assign cpu_stall_o = cpu_req_i & ~idle_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    cpu_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit && !cpu_we_i) cpu_data_o = data_q[idx][{word, 5'b0} +: 32];
        if (cpu_req_i && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = data_q[idx];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only valid/dirty need clearing: a line with valid = 0 never hits, so stale tags and data are harmless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (idle_hit && cpu_we_i) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: the tag/data arrays have no reset so they can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (idle_hit && cpu_we_i) begin
      data_q[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic,
// checked against a line-level cache/memory model and a bench-driven memory responder.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_data_i  (cpu_wdata),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: cache contents per index plus a sparse backing memory.
  bit          m_valid [16];
  bit          m_dirty [16];
  bit [22:0]   m_tag   [16];
  bit [255:0]  m_data  [16];
  bit [255:0]  mem     [bit [31:0]];

  int          acked = 0;
  int          fixed_delay = -1;
  logic [31:0] last_wb_addr, last_alloc_addr;
  logic [255:0] last_wb_data;

  always @(posedge clk_i) if (mem_ack && mem_enable_o) acked++;

  function automatic bit [255:0] get_line(input bit [31:0] a);
    if (!mem.exists(a))
      mem[a] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return mem[a];
  endfunction

  function automatic int pick_delay();
    return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Entered at a negedge with the DUT already in the phase; acks after d wait cycles.
  task automatic mem_phase(input bit wr, input logic [31:0] a, input logic [255:0] wline,
                           input logic [255:0] rline, input int d);
    for (int c = 0; c <= d; c++) begin
      #1;
      checks++;
      if (mem_enable_o !== 1'b1 || mem_write_o !== wr || mem_addr_o !== a || cpu_stall_o !== 1'b1) begin
        failures++;
        $display("FAIL mem_phase wr=%0b: got en=%b we=%b addr=%h stall=%b, want en=1 we=%b addr=%h stall=1",
                 wr, mem_enable_o, mem_write_o, mem_addr_o, cpu_stall_o, wr, a);
      end
      if (wr) begin
        checks++;
        if (mem_data_o !== wline) begin
          failures++;
          $display("FAIL wb_data: got %h want %h", mem_data_o, wline);
        end
        last_wb_addr = mem_addr_o;
        last_wb_data = mem_data_o;
      end else begin
        last_alloc_addr = mem_addr_o;
      end
      if (c == d) begin
        mem_ack   = 1'b1;
        mem_rdata = rline;
      end
      @(negedge clk_i);
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  // One CPU access from detect to completion; called and returns at a negedge.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [3:0]   idx;
    logic [22:0]  tg;
    int           w;
    bit           hit;
    logic [31:0]  la, wa;
    logic [255:0] line;
    logic [31:0]  exp_rd;
    idx = addr[8:5];
    tg  = addr[31:9];
    w   = int'(addr[4:2]);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    checks++;
    if (cpu_stall_o !== !hit || mem_enable_o !== 1'b0) begin
      failures++;
      $display("FAIL detect addr=%h: got stall=%b en=%b want stall=%b en=0", addr, cpu_stall_o, mem_enable_o, !hit);
    end
    if (!hit) begin
      @(negedge clk_i);
      if (m_valid[idx] && m_dirty[idx]) begin
        wa = {m_tag[idx], idx, 5'b0};
        mem_phase(1'b1, wa, m_data[idx], '0, pick_delay());
        mem[wa] = m_data[idx];
      end
      la   = {tg, idx, 5'b0};
      line = get_line(la);
      mem_phase(1'b0, la, '0, line, pick_delay());
      m_data[idx]  = line;
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      #1;
      checks++;
      if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
        failures++;
        $display("FAIL complete addr=%h: got stall=%b en=%b want stall=0 en=0", addr, cpu_stall_o, mem_enable_o);
      end
    end
    exp_rd = we ? 32'h0 : m_data[idx][w*32 +: 32];
    checks++;
    if (cpu_data_o !== exp_rd) begin
      failures++;
      $display("FAIL cpu_data addr=%h we=%b: got %h want %h", addr, we, cpu_data_o, exp_rd);
    end
    if (we) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
    @(negedge clk_i);
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || cpu_data_o !== 32'h0 ||
        mem_write_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b en=%b data=%h we=%b addr=%h, want all 0",
               cpu_stall_o, mem_enable_o, cpu_data_o, mem_write_o, mem_addr_o);
    end
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040;
    #1;
    checks++;
    if (cpu_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_read_stall: got %b want 1", cpu_stall_o);
    end
    cpu_req = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_clean_read_miss();
    int a0;
    logic [255:0] l;
    l = get_line(32'h0000_0040);
    l[63:32] = 32'hDEAD_BEEF;
    mem[32'h0000_0040] = l;
    fixed_delay = 3;
    a0 = acked;
    access(1'b0, 32'h0000_0044, '0);
    fixed_delay = -1;
    checks++;
    if (acked - a0 != 1 || last_alloc_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL clean_miss_requests: got n=%0d addr=%h want n=1 addr=00000040", acked - a0, last_alloc_addr);
    end
  endtask

  task automatic test_write_hit();
    int a0;
    a0 = acked;
    access(1'b1, 32'h0000_0048, 32'h1234_5678);
    access(1'b0, 32'h0000_0048, '0);
    checks++;
    if (acked != a0) begin
      failures++;
      $display("FAIL write_hit_no_mem: got %0d requests want 0", acked - a0);
    end
  endtask

  task automatic test_dirty_eviction();
    int a0;
    a0 = acked;
    access(1'b0, 32'h0000_0240, '0);
    checks++;
    if (acked - a0 != 2 || last_wb_addr !== 32'h0000_0040 || last_wb_data[95:64] !== 32'h1234_5678 ||
        last_alloc_addr !== 32'h0000_0240) begin
      failures++;
      $display("FAIL dirty_eviction: got n=%0d wb=%h w2=%h alloc=%h want n=2 wb=00000040 w2=12345678 alloc=00000240",
               acked - a0, last_wb_addr, last_wb_data[95:64], last_alloc_addr);
    end
  endtask

  task automatic test_reset_mid_allocate();
    bit ok;
    ok = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk_i);
      #1;
      ok = mem_enable_o;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_alloc_request: got en=0 want en=1 within 8 cycles");
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0 || cpu_data_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_alloc_reset: got en=%b we=%b addr=%h data=%h want all 0",
               mem_enable_o, mem_write_o, mem_addr_o, cpu_data_o);
    end
    cpu_req = 1'b0;
    model_reset();
    mem_ack = 1'b1;
    @(negedge clk_i);
    mem_ack = 1'b0;
    rst_i = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk_i);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL late_ack_ignored: got en=%b stall=%b want 0 0", mem_enable_o, cpu_stall_o);
    end
    @(negedge clk_i);
    access(1'b0, 32'h0000_0500, '0);
  endtask

  task automatic test_write_miss();
    int a0;
    a0 = acked;
    access(1'b1, 32'h0000_0100, 32'hCAFE_0001);
    checks++;
    if (acked - a0 != 1 || last_alloc_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL write_miss_alloc: got n=%0d addr=%h want n=1 addr=00000100", acked - a0, last_alloc_addr);
    end
    a0 = acked;
    access(1'b0, 32'h0000_0300, '0);
    checks++;
    if (acked - a0 != 2 || last_wb_addr !== 32'h0000_0100 || last_wb_data[31:0] !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL write_miss_evict: got n=%0d wb=%h w0=%h want n=2 wb=00000100 w0=cafe0001",
               acked - a0, last_wb_addr, last_wb_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      a = '0;
      a[31:9] = 23'($urandom_range(0, 2));
      a[8:5]  = 4'($urandom_range(0, 15));
      a[4:0]  = 5'($urandom);
      access(1'($urandom), a, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_clean_read_miss();
    test_write_hit();
    test_dirty_eviction();
    test_reset_mid_allocate();
    test_write_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
